// File: rtl/spi_speed_ramp.sv
// rtl/spi_speed_ramp.sv - slew-rate limited speed command feeding the PMD901 SPI register-write port
module spi_speed_ramp #(
    parameter logic [15:0] STEP     = 16'd256,
    parameter logic [15:0] INTERVAL = 16'd50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_speed,
    output logic        cmd_ready,
    input  logic        halt,
    output logic [15:0] wdata,
    output logic        we,
    output logic        at_target
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state_q;
    logic        [15:0] target_q;
    logic        [15:0] current_q;
    logic        [15:0] cnt_q;
    logic        [15:0] wdata_q;
    logic               we_q;

    logic signed [17:0] diff;
    logic signed [17:0] step_s;
    logic        [15:0] step_val;
    logic               step_reached;

    // Commands are refused for as long as halt is held.
    assign cmd_ready = ~halt;
    assign wdata     = wdata_q;
    assign we        = we_q;
    assign at_target = (state_q == S_IDLE) && (current_q == target_q);

    // Next commanded speed: move at most STEP toward target; widened diff avoids wrap.
    always_comb begin
        diff         = $signed({{2{target_q[15]}}, target_q}) - $signed({{2{current_q[15]}}, current_q});
        step_s       = $signed({2'b00, STEP});
        step_val     = target_q;
        if (diff > step_s) begin
            step_val = current_q + STEP;
        end else if (diff < -step_s) begin
            step_val = current_q - STEP;
        end
        step_reached = (step_val == target_q);
    end

    // Target register: halt forces zero, otherwise an accepted command loads it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target_q <= 16'd0;
        end else if (halt) begin
            target_q <= 16'd0;
        end else if (cmd_valid) begin
            target_q <= cmd_speed;
        end
    end

    // Ramp FSM: one write per step, steps spaced INTERVAL cycles apart.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            current_q <= 16'd0;
            wdata_q   <= 16'd0;
            we_q      <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (current_q != target_q) begin
                        current_q <= step_val;
                        wdata_q   <= step_val;
                        we_q      <= 1'b1;
                        if (!step_reached) begin
                            cnt_q   <= INTERVAL - 16'd1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (current_q == target_q) begin
                        // Target moved onto the current speed; nothing left to write.
                        state_q <= S_IDLE;
                    end else if (cnt_q == 16'd0) begin
                        current_q <= step_val;
                        wdata_q   <= step_val;
                        we_q      <= 1'b1;
                        if (step_reached) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= INTERVAL - 16'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_speed_ramp.sv
// tb/tb_spi_speed_ramp.sv - self-checking bench for spi_speed_ramp
module tb_spi_speed_ramp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cv;
    logic [15:0] cs;
    logic        cr;
    logic        h;
    logic [15:0] wd;
    logic        we;
    logic        at;

    logic        cv2;
    logic [15:0] cs2;
    logic        cr2;
    logic        h2;
    logic [15:0] wd2;
    logic        we2;
    logic        at2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_speed_ramp #(.STEP(16'd256), .INTERVAL(16'd4)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cv),
        .cmd_speed (cs),
        .cmd_ready (cr),
        .halt      (h),
        .wdata     (wd),
        .we        (we),
        .at_target (at)
    );

    spi_speed_ramp #(.STEP(16'd256), .INTERVAL(16'd1)) u_fast (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cv2),
        .cmd_speed (cs2),
        .cmd_ready (cr2),
        .halt      (h2),
        .wdata     (wd2),
        .we        (we2),
        .at_target (at2)
    );

    typedef struct {
        logic        v;
        logic [15:0] s;
        logic        h;
        logic        we;
        logic [15:0] wd;
        logic        at;
    } vec_t;

    vec_t tbl[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    function automatic void push(input logic v, input logic [15:0] s, input logic hh,
                                 input logic w, input logic [15:0] d, input logic a);
        vec_t e;
        e.v = v; e.s = s; e.h = hh; e.we = w; e.wd = d; e.at = a;
        tbl.push_back(e);
    endfunction

    function automatic void gap(input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) push(1'b0, 16'd0, 1'b0, 1'b0, d, 1'b0);
    endfunction

    // Drive inputs, advance one edge, land 1 time unit after it.
    task automatic cyc(input logic v, input logic [15:0] s, input logic hh);
        cv = v; cs = s; h = hh;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string nm, input logic w, input logic [15:0] d, input logic a);
        chk1({nm, ".we"}, we, w);
        chk16({nm, ".wdata"}, wd, d);
        chk1({nm, ".at"}, at, a);
    endtask

    initial begin
        int e;
        logic [15:0] ed;
        rstn = 1'b1; cv = 1'b0; cs = 16'd0; h = 1'b0;
        cv2 = 1'b0; cs2 = 16'd0; h2 = 1'b0;
        #2 rstn = 1'b0;
        #1;
        expect3("reset", 1'b0, 16'd0, 1'b1);
        chk1("reset.ready", cr, 1'b1);
        h = 1'b1; #1;
        chk1("reset.ready_halt", cr, 1'b0);
        h = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Ramp 0 -> 1000: pulses at +1,+5,+9,+13 after acceptance.
        push(1'b1, 16'd1000, 1'b0, 1'b0, 16'd0, 1'b0);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd256, 1'b0); gap(3, 16'd256);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd512, 1'b0); gap(3, 16'd512);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd768, 1'b0); gap(3, 16'd768);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd1000, 1'b1);
        push(1'b0, 16'd0, 1'b0, 1'b0, 16'd1000, 1'b1);
        push(1'b0, 16'd0, 1'b0, 1'b0, 16'd1000, 1'b1);
        // Ramp 1000 -> -300.
        push(1'b1, -16'sd300, 1'b0, 1'b0, 16'd1000, 1'b0);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd744, 1'b0); gap(3, 16'd744);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd488, 1'b0); gap(3, 16'd488);
        push(1'b0, 16'd0, 1'b0, 1'b1, 16'd232, 1'b0); gap(3, 16'd232);
        push(1'b0, 16'd0, 1'b0, 1'b1, -16'sd24, 1'b0); gap(3, -16'sd24);
        push(1'b0, 16'd0, 1'b0, 1'b1, -16'sd280, 1'b0); gap(3, -16'sd280);
        push(1'b0, 16'd0, 1'b0, 1'b1, -16'sd300, 1'b1);
        push(1'b0, 16'd0, 1'b0, 1'b0, -16'sd300, 1'b1);
        push(1'b0, 16'd0, 1'b0, 1'b0, -16'sd300, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].h);
            expect3($sformatf("vec%0d", i), tbl[i].we, tbl[i].wd, tbl[i].at);
        end

        // Reset in the middle of a WAIT: outputs clear at once, no pulse afterwards.
        cyc(1'b1, 16'd1000, 1'b0);
        expect3("rst.acc", 1'b0, -16'sd300, 1'b0);
        cyc(1'b0, 16'd0, 1'b0);
        expect3("rst.pulse", 1'b1, -16'sd44, 1'b0);
        cyc(1'b0, 16'd0, 1'b0);
        #3 rstn = 1'b0;
        #1;
        expect3("rst.async", 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'd0, 1'b0);
            expect3($sformatf("rst.hold%0d", i), 1'b0, 16'd0, 1'b1);
        end
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'd0, 1'b0);
            expect3($sformatf("rst.after%0d", i), 1'b0, 16'd0, 1'b1);
        end

        // Retarget mid-WAIT: 300 taken one cycle after the 512 pulse lands at the old slot.
        for (int k = 0; k <= 17; k++) begin
            cyc((k == 0 || k == 6), (k == 6) ? 16'd300 : 16'd1000, 1'b0);
            ed = (k < 1) ? 16'd0 : (k < 5) ? 16'd256 : (k < 9) ? 16'd512 : 16'd300;
            expect3($sformatf("retgt.c%0d", k), (k == 1 || k == 5 || k == 9), ed, (k >= 9));
        end

        // Halt from 768 with a command pending: ramps down to 0 and stays there.
        rstn = 1'b0; cyc(1'b0, 16'd0, 1'b0); rstn = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            cyc((k == 0), 16'd1000, 1'b0);
            ed = (k < 1) ? 16'd0 : (k < 5) ? 16'd256 : (k < 9) ? 16'd512 : 16'd768;
            expect3($sformatf("halt.up%0d", k), (k == 1 || k == 5 || k == 9), ed, 1'b0);
        end
        for (int k = 10; k <= 21; k++) begin
            cv = k[0]; cs = 16'd5000; h = 1'b1;
            #1;
            chk1($sformatf("halt.ready%0d", k), cr, 1'b0);
            @(posedge clk); #1;
            ed = (k < 13) ? 16'd768 : (k < 17) ? 16'd512 : (k < 21) ? 16'd256 : 16'd0;
            expect3($sformatf("halt.dn%0d", k), (k == 13 || k == 17 || k == 21), ed, (k == 21));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'd0, 1'b0);
            expect3($sformatf("halt.rel%0d", i), 1'b0, 16'd0, 1'b1);
        end

        // Full-scale swings at INTERVAL=1: back-to-back pulses, exact end points, no wrap.
        cv2 = 1'b1; cs2 = 16'h8000;
        @(posedge clk); #1;
        cv2 = 1'b0;
        chk1("fast.acc.we", we2, 1'b0);
        for (int k = 0; k < 128; k++) begin
            @(posedge clk); #1;
            e = -256 * (k + 1);
            chk1($sformatf("fast.neg%0d.we", k), we2, 1'b1);
            chk16($sformatf("fast.neg%0d.wdata", k), wd2, 16'(e));
        end
        chk1("fast.neg.at", at2, 1'b1);
        cv2 = 1'b1; cs2 = 16'h7FFF;
        @(posedge clk); #1;
        cv2 = 1'b0;
        chk1("fast.acc2.we", we2, 1'b0);
        chk16("fast.acc2.wdata", wd2, 16'h8000);
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            e = (k == 255) ? 32767 : -32768 + 256 * (k + 1);
            chk1($sformatf("fast.pos%0d.we", k), we2, 1'b1);
            chk16($sformatf("fast.pos%0d.wdata", k), wd2, 16'(e));
        end
        chk1("fast.pos.at", at2, 1'b1);
        @(posedge clk); #1;
        chk1("fast.end.we", we2, 1'b0);
        chk16("fast.end.wdata", wd2, 16'h7FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
